// File: rtl/sap1_trace_pkg.sv
// Shared types and helpers for the SAP-1 trace monitor.
//   trace_state_e  : capture FSM states
//   entry_w()      : packed trace entry width for a given core configuration
//   trace_entry_t  : entry layout for the default core widths, MSB first
//   pack_entry / unpack_entry : conversions between struct and flat vector
package sap1_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } trace_state_e;

  function automatic int unsigned entry_w(input int unsigned addr_w,
                                          input int unsigned data_w,
                                          input int unsigned cw_w,
                                          input int unsigned t_w);
    return addr_w + 4 * data_w + cw_w + t_w;
  endfunction

  localparam int unsigned ENTRY_W_DEFAULT = entry_w(4, 8, 12, 3);

  typedef struct packed {
    logic [3:0]  pc;
    logic [7:0]  ir;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [7:0]  bus;
    logic [11:0] cw;
    logic [2:0]  t_state;
  } trace_entry_t;

  function automatic logic [ENTRY_W_DEFAULT-1:0] pack_entry(input trace_entry_t e);
    return ENTRY_W_DEFAULT'(e);
  endfunction

  function automatic trace_entry_t unpack_entry(input logic [ENTRY_W_DEFAULT-1:0] v);
    return trace_entry_t'(v);
  endfunction

endpackage

// File: rtl/sap1_trace_monitor_if.sv
// Drain port of the trace monitor: valid/ready handshake carrying one entry.
//   rd_valid : master -> slave, rd_data holds a valid entry
//   rd_ready : slave -> master, entry accepted this cycle
//   rd_data  : master -> slave, packed entry
interface sap1_trace_monitor_if
  import sap1_trace_pkg::*;
#(
  parameter int unsigned ENTRY_W = ENTRY_W_DEFAULT
);
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/sap1_trace_ram.sv
// DEPTH x ENTRY_W simple dual-port trace RAM, one write port and one
// registered read port.
//   clk_in, rst : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read address, registered read data
module sap1_trace_ram #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 51
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  // Storage array, no reset.
  always_ff @(posedge clk_in) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Write-first bypass: a capture that ends on its first sample reads the
  // very slot being written on that edge.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata_q <= wdata;
    end else begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sap1_trace_monitor.sv
// On-chip trace/halt monitor for the SAP-1 core. Samples the core state each
// cycle into a circular buffer while armed, stops on HLT, cycle limit or
// stop, then drains entries oldest-first over a valid/ready port.
//   clk_in, rst          : clock, synchronous active-low reset
//   start, stop          : arm capture / force end of capture
//   pc..t_state          : core taps
//   rd                   : drain port (master)
//   busy                 : capture in progress
//   halted, timeout      : cause of the last capture end
//   overflow             : buffer wrapped, oldest samples lost
//   cycle_cnt            : samples taken in current/last capture
module sap1_trace_monitor
  import sap1_trace_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CW_W       = 12,
  parameter int unsigned HLT_BIT    = 11,
  parameter int unsigned T_W        = 3,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 100
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [DATA_W-1:0]   ir,
  input  logic [DATA_W-1:0]   a_reg,
  input  logic [DATA_W-1:0]   b_reg,
  input  logic [DATA_W-1:0]   bus,
  input  logic [CW_W-1:0]     cw,
  input  logic [T_W-1:0]      t_state,
  sap1_trace_monitor_if.master rd,
  output logic                busy,
  output logic                halted,
  output logic                timeout,
  output logic                overflow,
  output logic [15:0]         cycle_cnt
);
  localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W, CW_W, T_W);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned FW      = AW + 1;
  localparam int unsigned CNT_W   = 16;

  trace_state_e      state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              we_c;
  logic [ENTRY_W-1:0] wdata_c;
  logic [ENTRY_W-1:0] rdata;

  assign wdata_c = {pc, ir, a_reg, b_reg, bus, cw, t_state};

  // Read address is the next pointer so the registered read port always
  // presents the entry at rd_ptr_q.
  sap1_trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk_in (clk_in),
    .rst    (rst),
    .we     (we_c),
    .waddr  (wr_ptr_q),
    .wdata  (wdata_c),
    .raddr  (rd_ptr_d),
    .rdata  (rdata)
  );

  // Capture/drain FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    we_c       = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          wr_ptr_d   = '0;
          fill_d     = '0;
          cnt_d      = '0;
          halted_d   = 1'b0;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
        end else if (rd_valid_q && rd.rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          fill_d   = fill_q - FW'(1);
        end
      end
      RUN: begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        cnt_d    = cnt_q + CNT_W'(1);
        if (fill_q == FW'(DEPTH)) begin
          overflow_d = 1'b1;
        end else begin
          fill_d = fill_q + FW'(1);
        end
        if (cw[HLT_BIT]) begin
          halted_d = 1'b1;
          state_d  = DONE;
        end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else if (stop) begin
          state_d = DONE;
        end
        // Oldest entry; a full buffer truncates fill to 0 so rd_ptr == wr_ptr.
        rd_ptr_d = wr_ptr_d - AW'(fill_d);
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = (state_d == DONE) && (fill_d != '0);
    busy_d     = (state_d == RUN);
  end

  // State and status registers.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rdata;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_sap1_trace_monitor.sv
// Scoreboard bench for sap1_trace_monitor. Four instances cover the
// configurations under test: d0 default, d1 MAX_CYCLES=8, d2 DEPTH=4,
// d3 MAX_CYCLES=5. Captures push expected drain entries; a monitor pops
// and compares on every accepted handshake.
module tb_sap1_trace_monitor;
  import sap1_trace_pkg::*;

  localparam int unsigned EW = ENTRY_W_DEFAULT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [4];
  logic        stop;
  logic        rd_ready;
  logic [3:0]  pc;
  logic [7:0]  ir, a_reg, b_reg, bus;
  logic [11:0] cw;
  logic [2:0]  t_state;

  logic        busy [4], halted [4], timeout [4], overflow [4];
  logic [15:0] cnt [4];
  logic        rv [4];
  logic [EW-1:0] rdat [4];

  sap1_trace_monitor_if #(.ENTRY_W(EW)) rif0 ();
  sap1_trace_monitor_if #(.ENTRY_W(EW)) rif1 ();
  sap1_trace_monitor_if #(.ENTRY_W(EW)) rif2 ();
  sap1_trace_monitor_if #(.ENTRY_W(EW)) rif3 ();

  assign rif0.rd_ready = rd_ready;
  assign rif1.rd_ready = rd_ready;
  assign rif2.rd_ready = rd_ready;
  assign rif3.rd_ready = rd_ready;
  assign rv[0] = rif0.rd_valid; assign rdat[0] = rif0.rd_data;
  assign rv[1] = rif1.rd_valid; assign rdat[1] = rif1.rd_data;
  assign rv[2] = rif2.rd_valid; assign rdat[2] = rif2.rd_data;
  assign rv[3] = rif3.rd_valid; assign rdat[3] = rif3.rd_data;

  sap1_trace_monitor #(.DEPTH(16), .MAX_CYCLES(100)) u_d0 (
    .clk_in(clk), .rst(rst), .start(start[0]), .stop(stop), .pc(pc), .ir(ir),
    .a_reg(a_reg), .b_reg(b_reg), .bus(bus), .cw(cw), .t_state(t_state), .rd(rif0),
    .busy(busy[0]), .halted(halted[0]), .timeout(timeout[0]), .overflow(overflow[0]),
    .cycle_cnt(cnt[0]));
  sap1_trace_monitor #(.DEPTH(16), .MAX_CYCLES(8)) u_d1 (
    .clk_in(clk), .rst(rst), .start(start[1]), .stop(stop), .pc(pc), .ir(ir),
    .a_reg(a_reg), .b_reg(b_reg), .bus(bus), .cw(cw), .t_state(t_state), .rd(rif1),
    .busy(busy[1]), .halted(halted[1]), .timeout(timeout[1]), .overflow(overflow[1]),
    .cycle_cnt(cnt[1]));
  sap1_trace_monitor #(.DEPTH(4), .MAX_CYCLES(100)) u_d2 (
    .clk_in(clk), .rst(rst), .start(start[2]), .stop(stop), .pc(pc), .ir(ir),
    .a_reg(a_reg), .b_reg(b_reg), .bus(bus), .cw(cw), .t_state(t_state), .rd(rif2),
    .busy(busy[2]), .halted(halted[2]), .timeout(timeout[2]), .overflow(overflow[2]),
    .cycle_cnt(cnt[2]));
  sap1_trace_monitor #(.DEPTH(16), .MAX_CYCLES(5)) u_d3 (
    .clk_in(clk), .rst(rst), .start(start[3]), .stop(stop), .pc(pc), .ir(ir),
    .a_reg(a_reg), .b_reg(b_reg), .bus(bus), .cw(cw), .t_state(t_state), .rd(rif3),
    .busy(busy[3]), .halted(halted[3]), .timeout(timeout[3]), .overflow(overflow[3]),
    .cycle_cnt(cnt[3]));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int            dut;
    logic [EW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Sample k of a capture; base distinguishes successive captures.
  function automatic trace_entry_t mk(input int k, input bit h, input int base);
    trace_entry_t e;
    e.pc      = 4'(k);
    e.ir      = 8'(32 + k + base);
    e.a_reg   = 8'(3 * k + base);
    e.b_reg   = 8'(255 - k);
    e.bus     = 8'(k ^ base);
    e.cw      = h ? 12'(12'h800 | 12'(k)) : 12'(k);
    e.t_state = 3'(k % 5);
    return e;
  endfunction

  task automatic drive(input int k, input bit h, input int base);
    trace_entry_t e;
    e = mk(k, h, base);
    pc = e.pc; ir = e.ir; a_reg = e.a_reg; b_reg = e.b_reg;
    bus = e.bus; cw = e.cw; t_state = e.t_state;
  endtask

  // Expected drain: samples first..last of a capture, oldest first.
  task automatic push_range(input int d, input int first, input int last,
                            input int hlt_at, input int base);
    for (int k = first; k <= last; k++) begin
      exp_t x;
      x.dut  = d;
      x.data = pack_entry(mk(k, k == hlt_at, base));
      sb_q.push_back(x);
    end
  endtask

  // Arm DUT d and feed n samples; returns at the negedge after the last one.
  task automatic run_capture(input int d, input int n, input int hlt_at,
                             input int stop_at, input int mid_start, input int base);
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive(k, k == hlt_at, base);
      stop = (k == stop_at);
      if (k == mid_start) start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      if (k == 0 && n > 1) chk($sformatf("d%0d_busy_run", d), 64'(busy[d]), 64'd1);
    end
    stop = 1'b0;
    drive(0, 1'b0, 0);
  endtask

  task automatic chk_status(input int d, input bit h, input bit to, input bit ov, input int c);
    chk($sformatf("d%0d_busy", d), 64'(busy[d]), 64'd0);
    chk($sformatf("d%0d_halted", d), 64'(halted[d]), 64'(h));
    chk($sformatf("d%0d_timeout", d), 64'(timeout[d]), 64'(to));
    chk($sformatf("d%0d_overflow", d), 64'(overflow[d]), 64'(ov));
    chk($sformatf("d%0d_cycle_cnt", d), 64'(cnt[d]), 64'(c));
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int d, input int mode);
    int cyc = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 || cyc >= 80) break;
      rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      cyc++;
    end
    rd_ready = 1'b0;
    chk($sformatf("d%0d_drain_left", d), 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    chk($sformatf("d%0d_valid_after_drain", d), 64'(rv[d]), 64'd0);
  endtask

  // Scoreboard monitor, samples just before each active edge.
  bit            stall_pend [4];
  logic [EW-1:0] stall_data [4];
  initial for (int i = 0; i < 4; i++) stall_pend[i] = 1'b0;

  always @(negedge clk) begin
    #4;
    for (int i = 0; i < 4; i++) begin
      if (stall_pend[i]) begin
        chk($sformatf("d%0d_stall_valid", i), 64'(rv[i]), 64'd1);
        chk($sformatf("d%0d_stall_data", i), 64'(rdat[i]), 64'(stall_data[i]));
      end
      stall_pend[i] = rv[i] && !rd_ready && !start[i] && rst;
      stall_data[i] = rdat[i];
      if (rv[i] && rd_ready && rst) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("d%0d_unexpected_entry", i), 64'(rdat[i]), 64'd0);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chk($sformatf("d%0d_entry_dut", i), 64'(i), 64'(x.dut));
          chk($sformatf("d%0d_entry_pc%0d", i, unpack_entry(x.data).pc),
              64'(rdat[i]), 64'(x.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    drive(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_status(i, 1'b0, 1'b0, 1'b0, 0);
      chk($sformatf("d%0d_rst_valid", i), 64'(rv[i]), 64'd0);
      chk($sformatf("d%0d_rst_data", i), 64'(rdat[i]), 64'd0);
    end
    rst = 1'b1;

    // HLT on the 6th sample
    run_capture(0, 6, 5, -1, -1, 0);
    chk_status(0, 1'b1, 1'b0, 1'b0, 6);
    push_range(0, 0, 5, 5, 0);
    drain(0, 0);

    // cycle limit 8
    run_capture(1, 8, -1, -1, -1, 7);
    chk_status(1, 1'b0, 1'b1, 1'b0, 8);
    push_range(1, 0, 7, -1, 7);
    drain(1, 0);

    // DEPTH 4, stop on 10th sample: only samples 6..9 survive
    run_capture(2, 10, -1, 9, -1, 0);
    chk_status(2, 1'b0, 1'b0, 1'b1, 10);
    push_range(2, 6, 9, -1, 0);
    drain(2, 0);

    // HLT coinciding with the cycle limit: HLT wins
    run_capture(3, 5, 4, -1, -1, 3);
    chk_status(3, 1'b1, 1'b0, 1'b0, 5);
    push_range(3, 0, 4, 4, 3);
    drain(3, 0);

    // restart from DONE, start ignored mid-run, stalled drain
    run_capture(0, 10, 9, -1, 3, 40);
    chk_status(0, 1'b1, 1'b0, 1'b0, 10);
    push_range(0, 0, 9, 9, 40);
    drain(0, 1);

    // start in DONE discards an undrained capture
    run_capture(1, 3, -1, 2, -1, 11);
    chk_status(1, 1'b0, 1'b0, 1'b0, 3);
    repeat (2) @(negedge clk);
    run_capture(1, 2, 1, -1, -1, 90);
    chk_status(1, 1'b1, 1'b0, 1'b0, 2);
    push_range(1, 0, 1, 1, 90);
    drain(1, 0);

    // reset during RUN after overflow, then a clean capture
    run_capture(2, 5, -1, -1, -1, 5);
    chk("d2_busy_mid", 64'(busy[2]), 64'd1);
    chk("d2_overflow_mid", 64'(overflow[2]), 64'd1);
    chk("d2_cnt_mid", 64'(cnt[2]), 64'd5);
    drive(5, 1'b0, 5);
    rst = 1'b0;
    @(negedge clk);
    chk_status(2, 1'b0, 1'b0, 1'b0, 0);
    chk("d2_rst_valid_mid", 64'(rv[2]), 64'd0);
    chk("d2_rst_data_mid", 64'(rdat[2]), 64'd0);
    rst = 1'b1;
    run_capture(2, 3, -1, 2, -1, 60);
    chk_status(2, 1'b0, 1'b0, 1'b0, 3);
    push_range(2, 0, 2, -1, 60);
    drain(2, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
